// File: rtl/hfrv_trace_buffer_if.sv
// hfrv_trace_buffer_if: oldest-first readout stream of captured {pc, instr} entries
interface hfrv_trace_buffer_if #(parameter int DATA_W = 32);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic              rd_last;
  modport master (output rd_valid, rd_pc, rd_instr, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_pc, rd_instr, rd_last, output rd_ready);
endinterface

// File: rtl/hfrv_trace_buffer.sv
// hfrv_trace_buffer: circular retired-instruction history with trigger, post-trigger window and stream drain
module hfrv_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cap_valid,
  input  logic [DATA_W-1:0]          cap_pc,
  input  logic [DATA_W-1:0]          cap_instr,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       trig_in,
  input  logic                       trig_pc_en,
  input  logic [DATA_W-1:0]          trig_pc,
  input  logic                       rd_start,
  hfrv_trace_buffer_if.master        rd,
  output logic [2:0]                 state,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       wrapped,
  output logic [$clog2(DEPTH)-1:0]   trig_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, READ} st_t;
  st_t                  st;
  logic [AW-1:0]        wptr, raddr, post_cnt;
  logic [CW-1:0]        rem, cnt_nx, tix;
  logic                 pend, rv, rl, we, trig, ld;
  logic [2*DATA_W-1:0]  mem [DEPTH];
  logic [2*DATA_W-1:0]  q;
  assign we     = cap_valid && (st == ARMED || st == POST) && !abort;
  assign trig   = st == ARMED && (trig_in || (cap_valid && trig_pc_en && cap_pc == trig_pc));
  assign ld     = st == READ && rem != '0 && (!rv || rd.rd_ready) && !abort;
  assign cnt_nx = count == CW'(DEPTH) ? count : count + 1'b1;
  assign tix    = cnt_nx - CW'(POST_TRIG + 1);
  assign state  = st;
  // q is the read-enabled memory output register; it doubles as the stall-holding output stage
  assign rd.rd_valid = rv;
  assign rd.rd_last  = rl;
  assign rd.rd_pc    = rv ? q[2*DATA_W-1:DATA_W] : '0;
  assign rd.rd_instr = rv ? q[DATA_W-1:0] : '0;
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= {cap_pc, cap_instr};
    if (ld) q <= mem[raddr];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= IDLE;
      wptr     <= '0;
      count    <= '0;
      wrapped  <= 1'b0;
      trig_idx <= '0;
      post_cnt <= '0;
      pend     <= 1'b0;
      raddr    <= '0;
      rem      <= '0;
      rv       <= 1'b0;
      rl       <= 1'b0;
    end else if (abort) begin
      st    <= IDLE;
      count <= '0;
      pend  <= 1'b0;
      rv    <= 1'b0;
      rl    <= 1'b0;
    end else begin
      if (we) begin
        wptr    <= wptr + 1'b1;
        count   <= cnt_nx;
        wrapped <= wrapped || count == CW'(DEPTH);
      end
      case (st)
        IDLE, DONE:
          if (arm) begin
            st       <= ARMED;
            wptr     <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            trig_idx <= '0;
            pend     <= 1'b0;
          end else if (st == DONE && rd_start && count != '0) begin
            st    <= READ;
            raddr <= wptr - count[AW-1:0];
            rem   <= count;
          end
        ARMED:
          if (trig) begin
            post_cnt <= AW'(POST_TRIG);
            pend     <= !cap_valid;
            if (cap_valid && POST_TRIG == 0) begin
              st       <= DONE;
              trig_idx <= tix[AW-1:0];
            end else st <= POST;
          end
        POST:
          // a pending trigger makes the next capture the trigger entry, which does not consume the window
          if (cap_valid) begin
            if (pend) pend <= 1'b0;
            else post_cnt <= post_cnt - 1'b1;
            if (pend ? POST_TRIG == 0 : post_cnt == AW'(1)) begin
              st       <= DONE;
              trig_idx <= tix[AW-1:0];
            end
          end
        READ:
          if (ld) begin
            raddr <= raddr + 1'b1;
            rem   <= rem - 1'b1;
            rv    <= 1'b1;
            rl    <= rem == CW'(1);
          end else if (rv && rd.rd_ready) begin
            rv <= 1'b0;
            rl <= 1'b0;
            if (rl) st <= IDLE;
          end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// tb_hfrv_trace_buffer: directed checks of capture, trigger, wrap, drain, backpressure, reset and abort
module tb_hfrv_trace_buffer;
  logic        clk = 0, reset_n = 0, cap_valid = 0, arm = 0, abort = 0, trig_in = 0, trig_pc_en = 0, rd_start = 0;
  logic [31:0] cap_pc = 0, cap_instr = 0, trig_pc = 0;
  logic [2:0]  state;
  logic [3:0]  count;
  logic        wrapped;
  logic [2:0]  trig_idx;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  hfrv_trace_buffer_if #(.DATA_W(32)) rif ();
  hfrv_trace_buffer #(.DATA_W(32), .DEPTH(8), .POST_TRIG(3)) dut (
    .clk(clk), .reset_n(reset_n), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .arm(arm), .abort(abort), .trig_in(trig_in), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
    .rd_start(rd_start), .rd(rif), .state(state), .count(count), .wrapped(wrapped), .trig_idx(trig_idx)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_arm;
    arm = 1;
    tick;
    arm = 0;
  endtask
  task automatic cap(input logic [31:0] pc, input logic t);
    cap_valid = 1;
    cap_pc    = pc;
    cap_instr = pc ^ 32'hDEAD0000;
    trig_in   = t;
    tick;
    cap_valid = 0;
    trig_in   = 0;
  endtask
  task automatic expect_done(input string tag, input int cnt, input logic wr, input int ti);
    check({tag, "_state"}, state, 3);
    check({tag, "_count"}, count, cnt);
    check({tag, "_wrapped"}, wrapped, wr);
    check({tag, "_trig_idx"}, trig_idx, ti);
  endtask
  task automatic basic_fill;
    do_arm;
    check("arm_state", state, 1);
    cap(32'h100, 0);
    cap(32'h104, 0);
    cap(32'h108, 1);
    check("post_state", state, 2);
    cap(32'h10C, 0);
    cap(32'h110, 0);
    check("post_hold", state, 2);
    cap(32'h114, 0);
    expect_done("basic", 6, 0, 2);
  endtask
  task automatic drain(input logic [31:0] pc0, input int n, input bit bp);
    int          idx;
    bit          stalled, rdy;
    logic [31:0] hold;
    idx = 0;
    stalled = 0;
    hold = 0;
    rd_start = 1;
    tick;
    rd_start = 0;
    check("rv_early", rif.rd_valid, 0);
    tick;
    check("rv_lat2", rif.rd_valid, 1);
    for (int c = 0; c < 200 && idx < n; c++) begin
      rdy = !bp || (c % 3 == 0);
      if (stalled) check("stall_hold", {rif.rd_valid, rif.rd_pc}, {1'b1, hold});
      rif.rd_ready = rdy;
      if (rif.rd_valid && rdy) begin
        check("rd_pc", rif.rd_pc, 32'(pc0 + 4 * idx));
        check("rd_instr", rif.rd_instr, 32'(pc0 + 4 * idx) ^ 32'hDEAD0000);
        check("rd_last", rif.rd_last, idx == n - 1);
        idx++;
      end
      stalled = rif.rd_valid && !rdy;
      hold = rif.rd_pc;
      tick;
    end
    rif.rd_ready = 0;
    check("drain_n", idx, n);
    check("idle_after", state, 0);
    check("rv_after", rif.rd_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rif.rd_ready = 0;
    #1;
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_rv", rif.rd_valid, 0);
    check("rst_pc", rif.rd_pc, 0);
    check("rst_wrapped", wrapped, 0);
    tick;
    tick;
    reset_n = 1;
    tick;
    basic_fill;
    drain(32'h100, 6, 0);
    do_arm;
    trig_pc_en = 1;
    trig_pc = 32'h30;
    for (int i = 0; i < 12; i++) cap(32'(4 * i), 0);
    check("wrap_armed", state, 1);
    check("wrap_count", count, 8);
    check("wrap_flag", wrapped, 1);
    cap(32'h30, 0);
    check("wrap_post", state, 2);
    cap(32'h34, 0);
    cap(32'h38, 0);
    cap(32'h3C, 0);
    expect_done("wrap", 8, 1, 4);
    trig_pc_en = 0;
    drain(32'h20, 8, 0);
    basic_fill;
    drain(32'h100, 6, 1);
    do_arm;
    cap(32'h100, 1);
    cap(32'h104, 0);
    check("mid_post", state, 2);
    #2 reset_n = 0;
    #1;
    check("arst_state", state, 0);
    check("arst_count", count, 0);
    check("arst_rv", rif.rd_valid, 0);
    tick;
    reset_n = 1;
    tick;
    rd_start = 1;
    tick;
    rd_start = 0;
    tick;
    tick;
    check("rdstart_ign_state", state, 0);
    check("rdstart_ign_rv", rif.rd_valid, 0);
    arm = 1;
    trig_in = 1;
    tick;
    arm = 0;
    trig_in = 0;
    check("arm_trig_state", state, 1);
    cap(32'h300, 0);
    check("no_trig", state, 1);
    check("no_trig_count", count, 1);
    trig_in = 1;
    tick;
    trig_in = 0;
    check("pend_post", state, 2);
    cap(32'h304, 0);
    cap(32'h308, 0);
    cap(32'h30C, 0);
    check("pend_wait", state, 2);
    cap(32'h310, 0);
    expect_done("pend", 5, 0, 1);
    rd_start = 1;
    tick;
    rd_start = 0;
    tick;
    check("abort_rv_pre", rif.rd_valid, 1);
    check("abort_pc_pre", rif.rd_pc, 32'h300);
    abort = 1;
    tick;
    abort = 0;
    check("abort_state", state, 0);
    check("abort_rv", rif.rd_valid, 0);
    check("abort_count", count, 0);
    trig_pc_en = 1;
    trig_pc = 32'h200;
    do_arm;
    cap(32'h200, 0);
    check("early_post", state, 2);
    cap(32'h204, 0);
    cap(32'h208, 0);
    cap(32'h20C, 0);
    expect_done("early", 4, 0, 0);
    trig_pc_en = 0;
    drain(32'h200, 4, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
